// File: rtl/fft32_out_reorder_if.sv
// Stream bundle for the FFT output reorder stage: a dual-path bit-reversed input side
// and a single-path natural-order output side.
interface fft32_out_reorder_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_up_re;
  logic signed [WIDTH-1:0] in_up_im;
  logic signed [WIDTH-1:0] in_l_re;
  logic signed [WIDTH-1:0] in_l_im;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic [4:0]              out_index;
  logic                    out_last;

  modport master (
    output in_valid, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last
  );

  modport slave (
    input  in_valid, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last
  );
endinterface

// File: rtl/fft32_out_reorder.sv
// Ping-pong register buffer turning the 32-point MDC FFT's bit-reversed dual-path
// output into a natural-order single-path stream with valid/ready handshake.
module fft32_out_reorder #(
  parameter int WIDTH = 9
) (
  input logic                clk,
  input logic                rst_n,
  fft32_out_reorder_if.slave bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  logic [0:0]              state_q, state_d;
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [3:0]              wr_cnt_q, wr_cnt_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [4:0]              rd_cnt_q, rd_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_re_q, out_re_d;
  logic signed [WIDTH-1:0] out_im_q, out_im_d;

  logic signed [WIDTH-1:0] mem_re_q [2][32];
  logic signed [WIDTH-1:0] mem_im_q [2][32];

  logic       in_ready;
  logic       wr_fire;
  logic [4:0] wr_addr_up;
  logic [4:0] wr_addr_lo;
  logic       advance;
  logic       load;
  logic       rd_sel_bank;
  logic [4:0] rd_sel_addr;

  assign in_ready   = ~full_q[wr_bank_q];
  assign wr_fire    = bus.in_valid & in_ready;
  assign wr_addr_up = {1'b0, rev4(wr_cnt_q)};
  assign wr_addr_lo = {1'b1, rev4(wr_cnt_q)};
  assign advance    = bus.out_ready | ~out_valid_q;

  // Buffer contents need no reset: a frame is only read after all 32 words are written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_re_q[wr_bank_q][wr_addr_up] <= bus.in_up_re;
      mem_im_q[wr_bank_q][wr_addr_up] <= bus.in_up_im;
      mem_re_q[wr_bank_q][wr_addr_lo] <= bus.in_l_re;
      mem_im_q[wr_bank_q][wr_addr_lo] <= bus.in_l_im;
    end
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    load        = 1'b0;
    rd_sel_bank = rd_bank_q;
    rd_sel_addr = rd_cnt_q + 5'd1;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          load        = 1'b1;
          rd_sel_addr = 5'd0;
          rd_cnt_d    = 5'd0;
          out_valid_d = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (advance) begin
          if (rd_cnt_q != 5'd31) begin
            load        = 1'b1;
            rd_cnt_d    = rd_cnt_q + 5'd1;
            out_valid_d = 1'b1;
          end else begin
            // Writer only ever touches the non-full bank, so this clear never collides
            // with a set of the same flag above.
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = 5'd0;
            if (full_q[~rd_bank_q]) begin
              load        = 1'b1;
              rd_sel_bank = ~rd_bank_q;
              rd_sel_addr = 5'd0;
              out_valid_d = 1'b1;
            end else begin
              out_valid_d = 1'b0;
              state_d     = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (load) begin
      out_re_d = mem_re_q[rd_sel_bank][rd_sel_addr];
      out_im_d = mem_im_q[rd_sel_bank][rd_sel_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_index = rd_cnt_q;
  assign bus.out_last  = out_valid_q & (rd_cnt_q == 5'd31);

endmodule

// File: tb/tb_fft32_out_reorder.sv
// Directed bench for fft32_out_reorder: frames are tagged by a per-frame base so that
// bin b of frame f must come out as re = base+b, im = -(base+b).
module tb_fft32_out_reorder;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft32_out_reorder_if #(.WIDTH(W)) bus();

  fft32_out_reorder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_re[$];
  int exp_idx[$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  function automatic int base_of(input int f);
    return (f == 0) ? 0 : (((f * 53) % 224) - 100);
  endfunction

  // Output scoreboard: every valid cycle must show the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid) begin
      if (exp_re.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_index", int'(bus.out_index), exp_idx[0]);
        check("out_re", int'($signed(bus.out_re)), exp_re[0]);
        check("out_im", int'($signed(bus.out_im)), -exp_re[0]);
        check("out_last", int'(bus.out_last), int'(exp_idx[0] == 31));
        if (bus.out_ready) begin
          void'(exp_re.pop_front());
          void'(exp_idx.pop_front());
        end
      end
    end
  end

  task automatic push_frame(input int f);
    for (int b = 0; b < 32; b++) begin
      exp_re.push_back(base_of(f) + b);
      exp_idx.push_back(b);
    end
  endtask

  task automatic drive_beat(input int f, input int k);
    int bin;
    bin = rev4(k);
    bus.in_valid = 1'b1;
    bus.in_up_re = W'(base_of(f) + bin);
    bus.in_up_im = W'(-(base_of(f) + bin));
    bus.in_l_re  = W'(base_of(f) + 16 + bin);
    bus.in_l_im  = W'(-(base_of(f) + 16 + bin));
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the beat.
  task automatic send_beat(input int f, input int k, input int gap_max);
    int  n;
    bit  acc;
    if (gap_max > 0) begin
      repeat ($urandom_range(gap_max, 0)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    drive_beat(f, k);
    n = 0;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 300) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int f, input int gap_max);
    push_frame(f);
    for (int k = 0; k < 16; k++) send_beat(f, k, gap_max);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_re.size() > 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", exp_re.size(), 0);
    @(negedge clk);
    check("idle_after_drain", int'(bus.out_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_re"}, int'($signed(bus.out_re)), 0);
    check({tag, "_out_im"}, int'($signed(bus.out_im)), 0);
    check({tag, "_out_index"}, int'(bus.out_index), 0);
    check({tag, "_out_last"}, int'(bus.out_last), 0);
  endtask

  task automatic pulse_reset(input string tag);
    mon_en = 1'b0;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    exp_re.delete();
    exp_idx.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_up_re  = '0;
    bus.in_up_im  = '0;
    bus.in_l_re   = '0;
    bus.in_l_im   = '0;
    bus.out_ready = 1'b1;

    #12 check_reset_outputs("reset");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Single frame, plain ramp; bin 0 appears one edge after the last beat.
    send_frame(0, 0);
    @(negedge clk);
    check("lat_before", int'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_bin0_valid", int'(bus.out_valid), 1);
    check("lat_bin0_index", int'(bus.out_index), 0);
    @(posedge clk); #1;
    wait_drain();

    // Continuous input over three frames with in_ready tracked per cycle.
    push_frame(1);
    push_frame(2);
    push_frame(3);
    fork
      begin
        int beat;
        int t;
        bit acc;
        bit e;
        beat = 0;
        t = 0;
        while (beat < 48 && t < 300) begin
          drive_beat(1 + beat / 16, beat % 16);
          @(negedge clk);
          e = (t < 32) || (t >= 49 && t < 65);
          check("cont_in_ready", int'(bus.in_ready), int'(e));
          acc = bus.in_ready;
          @(posedge clk); #1;
          t++;
          if (acc) beat++;
        end
        bus.in_valid = 1'b0;
        check("cont_beats", beat, 48);
      end
      begin
        int m;
        int gaps;
        m = 0;
        gaps = 0;
        @(negedge clk);
        while (!bus.out_valid && m < 100) begin
          @(negedge clk);
          m++;
        end
        repeat (95) begin
          @(negedge clk);
          if (!bus.out_valid) gaps++;
        end
        check("cont_bubbles", gaps, 0);
      end
    join
    @(posedge clk); #1;
    wait_drain();

    // Output stall of five cycles on bin 7.
    send_frame(4, 0);
    n = 0;
    while (!(bus.out_valid && bus.out_index == 5'd7) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_found_bin7", int'(bus.out_index), 7);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_index", int'(bus.out_index), 7);
      check("stall_re", int'($signed(bus.out_re)), base_of(4) + 7);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_index", int'(bus.out_index), 7);
    @(negedge clk);
    check("after_stall_index", int'(bus.out_index), 8);
    @(posedge clk); #1;
    wait_drain();

    // Random gaps inside frames.
    send_frame(5, 3);
    send_frame(6, 2);
    wait_drain();

    // Reset after beat 9 of an input frame.
    push_frame(7);
    for (int k = 0; k < 10; k++) send_beat(7, k, 0);
    pulse_reset("rst_in");
    send_frame(8, 0);
    wait_drain();

    // Reset while bin 12 is on the output.
    send_frame(9, 0);
    n = 0;
    while (!(bus.out_valid && bus.out_index == 5'd12) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_out_found_bin12", int'(bus.out_index), 12);
    pulse_reset("rst_out");
    send_frame(10, 0);
    wait_drain();

    // Both banks full, downstream stalled: poisoned input must be ignored.
    bus.out_ready = 1'b0;
    send_frame(11, 0);
    send_frame(12, 0);
    @(negedge clk);
    check("both_full_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_up_re = W'(-1);
    bus.in_up_im = W'(-1);
    bus.in_l_re  = W'(-1);
    bus.in_l_im  = W'(-1);
    repeat (6) begin
      @(negedge clk);
      check("full_block_in_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft32_out_reorder.md
Name: fft32_out_reorder

Overview:
- Output-side consumer of the 32-point MDC FFT pipeline.
- Accepts the final stage's dual-path result stream: two complex samples per beat, bins in bit-reversed order.
- Buffers each frame in a ping-pong register store and emits it as a single-path, natural-order stream (bin 0..31) with a valid/ready handshake.
- Sits between the last FFT stage and downstream consumers; provides backpressure to the FFT via in_ready.

Parameters:
WIDTH, 9, bit width of each signed real/imag component (input and output).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upper/lower pair valid this cycle
in_ready  output  1  block can accept a pair this cycle
in_up_re  input  WIDTH  upper-path real, signed
in_up_im  input  WIDTH  upper-path imag, signed
in_l_re  input  WIDTH  lower-path real, signed
in_l_im  input  WIDTH  lower-path imag, signed
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts sample
out_re  output  WIDTH  output real, signed
out_im  output  WIDTH  output imag, signed
out_index  output  5  bin number of current output sample
out_last  output  1  high with bin 31

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state: in_ready=1, out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0. Both bank_full flags, wr_bank, wr_cnt, rd_bank and rd_cnt are cleared.
- Reset mid-operation: any partial or undrained frame is discarded. Buffer contents are don't-care.
- Input ordering is fixed:
  - Accepted beat k (k = 0..15) of a frame carries bin rev4(k) on the up path and bin 16+rev4(k) on the lower path.
  - rev4 is the 4-bit bit reversal, so k=1 carries bins 8 and 24.
- Storage: two banks of 32 complex words each, held in registers.
- Write side:
  - Accept occurs when in_valid and in_ready are both high.
  - On accept, the up sample is written to bank[wr_bank][rev4(wr_cnt)] and the lower sample to bank[wr_bank][16+rev4(wr_cnt)]. wr_cnt then increments.
  - On the accept with wr_cnt=15: bank_full[wr_bank] is set, wr_bank toggles, and wr_cnt wraps to 0.
  - in_ready = !bank_full[wr_bank]. It is a combinational function of registered flags.
  - in_valid while in_ready=0 has no effect. Data is not captured.
- Read side, two-state FSM:
  - IDLE:
    - Entered on reset.
    - Transition to STREAM when bank_full[rd_bank]=1. That same edge loads the output register with bin 0 and sets out_valid=1.
    - Frame-latency figure: if the last input beat is accepted at edge N, bin 0 is on the outputs after edge N+1.
  - STREAM:
    - The output register advances when out_ready=1 or out_valid=0.
    - On advance with rd_cnt<31: load bin rd_cnt+1 and increment rd_cnt.
    - When bin 31 is accepted, that edge clears bank_full[rd_bank] and toggles rd_bank.
    - If the new rd_bank is already full, the same edge loads its bin 0: no bubble, out_valid stays 1. Otherwise out_valid falls to 0 and the FSM returns to IDLE.
  - out_index = bin held in the output register. out_last = out_valid and out_index==31.
- Output hold: out_re, out_im, out_index and out_last stay stable while out_valid=1 and out_ready=0.
- Sustained throughput: one output sample per cycle with out_ready=1. Input averages one beat per two cycles.
- Simultaneous events:
  - Writer completing a frame in one bank while the reader frees the other: both take effect on the same edge.
  - A freed bank is writable from the next cycle.
  - Writer and reader never address the same bank while it is partially written, because the writer only fills non-full banks.
- Arithmetic: pure data movement, no arithmetic. Widths are preserved; signed values pass through bit-exact.

Test Plan:
- Single frame, out_ready=1: beat k drives up_re=rev4(k), l_re=16+rev4(k), im=-(re); last beat accepted at edge N -> out_valid high after edge N+1; out_re=0,1,...,31 and out_im=0,-1,...,-31 on 32 consecutive cycles; out_last only on index 31; then out_valid=0.
- Continuous input (in_valid=1 every cycle), out_ready=1 -> in_ready high for the first 32 cycles (two frames); in_ready low from cycle 32 until the cycle after bin 31 of frame 0 is accepted; output frames are back-to-back with no bubble; all 64 samples are correct.
- Output stall: hold out_ready=0 for 5 cycles at bin 7 -> out_re=7 and out_index=7 are stable throughout; bin 8 follows on the first cycle with out_ready=1; no loss or duplication.
- Input gaps: in_valid toggles 1/0 with random gaps inside a frame -> only accepted beats counted; output is identical to the gap-free case.
- Reset mid-frame: assert rst_n=0 after beat 9 of frame 0 and after bin 12 of an output frame -> all outputs go to reset values asynchronously; after release, a fresh full frame produces bins 0..31 correctly with no residue.
- Both banks full with out_ready=0 -> in_ready=0; asserting in_valid with data 0x1FF does not corrupt stored frames (verified on drain).
